// File: rtl/fc2_bias_requant.sv
// Purpose: per-lane fc2 bias add, optional ReLU, rounding requantization to signed int8 with saturation.
// Latency: 2 cycles (vector accepted at edge N is presented with out_valid after edge N+1); 1 vector/cycle.
// Backpressure: valid/ready; holds at most 2 vectors, in_ready is the stage-1 enable (independent of in_valid).
module fc2_bias_requant #(
  parameter int NUM_NEURONS = 16,
  parameter int ACC_WIDTH   = 32,
  parameter int OUT_WIDTH   = 8,
  parameter int SHIFT       = 8,
  parameter int RELU_EN     = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_NEURONS*ACC_WIDTH-1:0] bias,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [NUM_NEURONS*ACC_WIDTH-1:0] in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [NUM_NEURONS*OUT_WIDTH-1:0] out_data,
  output logic [15:0]                      sat_count
);

  // Sums are formed one bit wider than a lane so overflow is visible before clamping.
  localparam int SW    = ACC_WIDTH + 1;
  localparam int CW    = $clog2(2 * NUM_NEURONS + 1);
  localparam int RND_I = (SHIFT > 0) ? (1 << ((SHIFT > 0) ? SHIFT - 1 : 0)) : 0;

  localparam logic signed [SW-1:0] RND  = SW'(RND_I);
  localparam logic signed [SW-1:0] QMAX = SW'((1 << (OUT_WIDTH - 1)) - 1);
  localparam logic signed [SW-1:0] QMIN = SW'(-(1 << (OUT_WIDTH - 1)));
  localparam logic [ACC_WIDTH-1:0] AMAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] AMIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic                             r_s1_valid;
  logic [NUM_NEURONS*ACC_WIDTH-1:0] r_s1_dat;
  logic [NUM_NEURONS-1:0]           r_s1_sat;
  logic                             r_out_valid;
  logic [NUM_NEURONS*OUT_WIDTH-1:0] r_out_data;
  logic [15:0]                      r_sat_count;

  logic                             w_s1_en;
  logic                             w_s2_en;
  logic                             w_s1_ld;
  logic                             w_s2_ld;
  logic [NUM_NEURONS*ACC_WIDTH-1:0] w_s1_dat;
  logic [NUM_NEURONS-1:0]           w_s1_sat;
  logic [NUM_NEURONS*OUT_WIDTH-1:0] w_s2_dat;
  logic [NUM_NEURONS-1:0]           w_s2_sat;
  logic [CW-1:0]                    w_inc;
  logic [16:0]                      w_cnt_sum;

  // A stage may load when it is empty or its contents are leaving this cycle.
  assign w_s2_en   = !r_out_valid || out_ready;
  assign w_s1_en   = !r_s1_valid || w_s2_en;
  assign w_s1_ld   = w_s1_en && in_valid;
  assign w_s2_ld   = w_s2_en && r_s1_valid;
  assign in_ready  = w_s1_en;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign sat_count = r_sat_count;

  // Stage-1 datapath: 33-bit bias add per lane, clamped back to the 32-bit range.
  always_comb begin
    logic [ACC_WIDTH-1:0]   w_a;
    logic [ACC_WIDTH-1:0]   w_b;
    logic signed [SW-1:0]   w_sum;
    w_a      = '0;
    w_b      = '0;
    w_sum    = '0;
    w_s1_dat = '0;
    w_s1_sat = '0;
    for (int i = 0; i < NUM_NEURONS; i++) begin
      w_a   = in_data[i*ACC_WIDTH +: ACC_WIDTH];
      w_b   = bias[i*ACC_WIDTH +: ACC_WIDTH];
      w_sum = $signed({w_a[ACC_WIDTH-1], w_a}) + $signed({w_b[ACC_WIDTH-1], w_b});
      if (w_sum[SW-1] != w_sum[SW-2]) begin
        w_s1_sat[i] = 1'b1;
        w_s1_dat[i*ACC_WIDTH +: ACC_WIDTH] = w_sum[SW-1] ? AMIN : AMAX;
      end else begin
        w_s1_dat[i*ACC_WIDTH +: ACC_WIDTH] = w_sum[ACC_WIDTH-1:0];
      end
    end
  end

  // Stage-2 datapath: ReLU, round-half-up arithmetic shift, clamp to the output range.
  always_comb begin
    logic [ACC_WIDTH-1:0] w_r;
    logic signed [SW-1:0] w_q;
    w_r      = '0;
    w_q      = '0;
    w_s2_dat = '0;
    w_s2_sat = '0;
    for (int i = 0; i < NUM_NEURONS; i++) begin
      w_r = r_s1_dat[i*ACC_WIDTH +: ACC_WIDTH];
      if ((RELU_EN != 0) && w_r[ACC_WIDTH-1]) begin
        w_r = '0;
      end
      w_q = ($signed({w_r[ACC_WIDTH-1], w_r}) + RND) >>> SHIFT;
      if (w_q > QMAX) begin
        w_s2_sat[i] = 1'b1;
        w_s2_dat[i*OUT_WIDTH +: OUT_WIDTH] = QMAX[OUT_WIDTH-1:0];
      end else if (w_q < QMIN) begin
        w_s2_sat[i] = 1'b1;
        w_s2_dat[i*OUT_WIDTH +: OUT_WIDTH] = QMIN[OUT_WIDTH-1:0];
      end else begin
        w_s2_dat[i*OUT_WIDTH +: OUT_WIDTH] = w_q[OUT_WIDTH-1:0];
      end
    end
  end

  // Lanes clamped at stage 1 are counted on entry; stage 2 only adds lanes not already counted.
  always_comb begin
    w_inc = '0;
    for (int i = 0; i < NUM_NEURONS; i++) begin
      if (w_s1_ld && w_s1_sat[i]) begin
        w_inc = w_inc + CW'(1);
      end
      if (w_s2_ld && w_s2_sat[i] && !r_s1_sat[i]) begin
        w_inc = w_inc + CW'(1);
      end
    end
  end

  assign w_cnt_sum = {1'b0, r_sat_count} + 17'(w_inc);

  // Pipeline registers: each stage's valid, data and flags move only on that stage's enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_dat    <= '0;
      r_s1_sat    <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      if (w_s1_en) begin
        r_s1_valid <= in_valid;
        r_s1_dat   <= w_s1_dat;
        r_s1_sat   <= w_s1_sat;
      end
      if (w_s2_en) begin
        r_out_valid <= r_s1_valid;
        r_out_data  <= w_s2_dat;
      end
    end
  end

  // Saturation counter sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sat_count <= '0;
    end else if (w_cnt_sum[16]) begin
      r_sat_count <= 16'hFFFF;
    end else begin
      r_sat_count <= w_cnt_sum[15:0];
    end
  end

endmodule

// File: tb/tb_fc2_bias_requant.sv
// Directed bench for fc2_bias_requant: two instances (ReLU on / ReLU off) share all inputs.
// Inputs change on the falling edge; outputs are sampled 1ns later, away from the rising edge.
// Expected values are hand-derived constants or simple closed-form lane formulas.
module tb_fc2_bias_requant;

  logic         clk;
  logic         rst_n;
  logic [511:0] bias;
  logic [511:0] in_data;
  logic         in_valid;
  logic         out_ready;
  logic         in_ready;
  logic         out_valid;
  logic [127:0] out_data;
  logic [15:0]  sat_count;
  logic         in_ready_nr;
  logic         out_valid_nr;
  logic [127:0] out_data_nr;
  logic [15:0]  sat_count_nr;

  int checks = 0;
  int errors = 0;

  fc2_bias_requant #(.NUM_NEURONS(16), .ACC_WIDTH(32), .OUT_WIDTH(8), .SHIFT(8), .RELU_EN(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .bias(bias), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .sat_count(sat_count)
  );

  fc2_bias_requant #(.NUM_NEURONS(16), .ACC_WIDTH(32), .OUT_WIDTH(8), .SHIFT(8), .RELU_EN(0)) u_dut_nr (
    .clk(clk), .rst_n(rst_n), .bias(bias), .in_valid(in_valid), .in_ready(in_ready_nr),
    .in_data(in_data), .out_valid(out_valid_nr), .out_ready(out_ready), .out_data(out_data_nr),
    .sat_count(sat_count_nr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [511:0] fill32(input logic [31:0] v);
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = v;
    return r;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; bias = '0; in_data = '0;
    #12;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (out_data !== 128'h0) begin errors++; $display("FAIL reset_out_data got %h exp 0", out_data); end
    checks++; if (sat_count !== 16'h0) begin errors++; $display("FAIL reset_sat_count got %h exp 0", sat_count); end
    @(negedge clk); rst_n = 1'b1; #1;
    checks++; if (in_ready !== 1'b1 || in_ready_nr !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b/%b exp 1", in_ready, in_ready_nr); end
  endtask

  // One vector, bias lane i = 256*i, data 1000 -> out lane i = 4+i.
  task automatic test_basic(input string tag);
    logic [127:0] exp;
    for (int i = 0; i < 16; i++) begin
      bias[i*32 +: 32] = 32'(i * 256);
      exp[i*8 +: 8]    = 8'(4 + i);
    end
    in_data = fill32(32'd1000); out_ready = 1'b1;
    @(negedge clk); in_valid = 1'b1; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL %s_in_ready got %b exp 1", tag, in_ready); end
    @(negedge clk); in_valid = 1'b0; #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_early_valid got %b exp 0", tag, out_valid); end
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL %s_latency_valid got %b exp 1", tag, out_valid); end
    checks++; if (out_data !== exp) begin errors++; $display("FAIL %s_data got %h exp %h", tag, out_data, exp); end
    checks++; if (sat_count !== 16'h0) begin errors++; $display("FAIL %s_sat_count got %h exp 0", tag, sat_count); end
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_drained got %b exp 0", tag, out_valid); end
  endtask

  // Sums -128,127,128,-1,-129,-300,-40000 in lanes 0..6, zero elsewhere.
  task automatic test_round_relu();
    logic [127:0] exp_relu;
    logic [127:0] exp_norelu;
    bias = '0; in_data = '0;
    in_data[0*32 +: 32] = 32'hFFFFFF80;
    in_data[1*32 +: 32] = 32'h0000007F;
    in_data[2*32 +: 32] = 32'h00000080;
    in_data[3*32 +: 32] = 32'hFFFFFFFF;
    in_data[4*32 +: 32] = 32'hFFFFFF7F;
    in_data[5*32 +: 32] = 32'hFFFFFED4;
    in_data[6*32 +: 32] = 32'hFFFF63C0;
    exp_relu   = '0; exp_relu[2*8 +: 8] = 8'h01;
    exp_norelu = '0;
    exp_norelu[2*8 +: 8] = 8'h01;
    exp_norelu[4*8 +: 8] = 8'hFF;
    exp_norelu[5*8 +: 8] = 8'hFF;
    exp_norelu[6*8 +: 8] = 8'h80;
    @(negedge clk); in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out_valid_nr !== 1'b1) begin errors++; $display("FAIL round_valid got %b/%b exp 1", out_valid, out_valid_nr); end
    checks++; if (out_data !== exp_relu) begin errors++; $display("FAIL round_relu_data got %h exp %h", out_data, exp_relu); end
    checks++; if (out_data_nr !== exp_norelu) begin errors++; $display("FAIL round_norelu_data got %h exp %h", out_data_nr, exp_norelu); end
    checks++; if (sat_count !== 16'd0) begin errors++; $display("FAIL round_relu_sat got %0d exp 0", sat_count); end
    checks++; if (sat_count_nr !== 16'd1) begin errors++; $display("FAIL round_norelu_sat got %0d exp 1", sat_count_nr); end
    @(negedge clk);
  endtask

  task automatic test_saturation();
    bias = fill32(32'h00000100); in_data = fill32(32'h7FFFFFF0); out_ready = 1'b1;
    @(negedge clk); in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk); #1;
    checks++; if (out_data !== {16{8'h7F}}) begin errors++; $display("FAIL sat_data got %h exp all 7f", out_data); end
    checks++; if (sat_count !== 16'd16) begin errors++; $display("FAIL sat_count_first got %0d exp 16", sat_count); end
    // 4094 more vectors: 4095 * 16 = 65520
    for (int n = 0; n < 4094; n++) begin @(negedge clk); in_valid = 1'b1; end
    @(negedge clk); in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (sat_count !== 16'hFFF0) begin errors++; $display("FAIL sat_count_65520 got %h exp fff0", sat_count); end
    // Two more vectors push past 65535 and must stick.
    for (int n = 0; n < 2; n++) begin @(negedge clk); in_valid = 1'b1; end
    @(negedge clk); in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (sat_count !== 16'hFFFF) begin errors++; $display("FAIL sat_count_sticky got %h exp ffff", sat_count); end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    @(negedge clk); in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0; #1;
    checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL mid_full got valid %b ready %b exp 1 0", out_valid, in_ready); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b exp 0", out_valid); end
    checks++; if (sat_count !== 16'h0) begin errors++; $display("FAIL mid_rst_sat got %h exp 0", sat_count); end
    @(negedge clk); rst_n = 1'b1;
    test_basic("after_rst");
  endtask

  // 10 vectors, lane i of vector k -> k+1+2i, with out_ready cycling 0,0,1.
  task automatic test_backpressure();
    int sent = 0;
    int recv = 0;
    logic         exp_rdy;
    logic [127:0] exp;
    logic [127:0] prev_data = '0;
    logic         prev_stall = 1'b0;
    bias = '0;
    for (int c = 0; c < 60 && recv < 10; c++) begin
      @(negedge clk);
      in_valid  = (sent < 10);
      for (int i = 0; i < 16; i++) in_data[i*32 +: 32] = 32'((sent + 1 + 2 * i) * 256);
      out_ready = ((c % 3) == 2);
      #1;
      exp_rdy = ((sent - recv) < 2) || out_ready;
      checks++; if (in_ready !== exp_rdy) begin errors++; $display("FAIL bp_in_ready cycle %0d got %b exp %b", c, in_ready, exp_rdy); end
      if ((sent - recv) == 2) begin
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_full_valid cycle %0d got %b exp 1", c, out_valid); end
      end
      if (prev_stall) begin
        checks++; if (out_valid !== 1'b1 || out_data !== prev_data) begin errors++; $display("FAIL bp_stall_hold cycle %0d got %b %h exp 1 %h", c, out_valid, out_data, prev_data); end
      end
      if (out_valid) begin
        for (int i = 0; i < 16; i++) exp[i*8 +: 8] = 8'(recv + 1 + 2 * i);
        checks++; if (out_data !== exp) begin errors++; $display("FAIL bp_order item %0d got %h exp %h", recv, out_data, exp); end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) recv++;
    end
    @(negedge clk); in_valid = 1'b0;
    checks++; if (recv !== 10) begin errors++; $display("FAIL bp_count got %0d exp 10", recv); end
  endtask

  // 64 vectors at full rate, lane i of vector k -> k+i, outputs on consecutive cycles.
  task automatic test_full_rate();
    logic [127:0] exp;
    bias = '0; out_ready = 1'b1;
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      in_valid = (c < 64);
      for (int i = 0; i < 16; i++) in_data[i*32 +: 32] = 32'((c + i) * 256);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fr_in_ready cycle %0d got %b exp 1", c, in_ready); end
      if (c >= 2 && c < 66) begin
        for (int i = 0; i < 16; i++) exp[i*8 +: 8] = 8'(c - 2 + i);
        checks++; if (out_valid !== 1'b1 || out_data !== exp) begin errors++; $display("FAIL fr_out cycle %0d got %b %h exp 1 %h", c, out_valid, out_data, exp); end
      end else begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fr_idle cycle %0d got %b exp 0", c, out_valid); end
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic("basic");
    test_round_relu();
    test_saturation();
    test_reset_midstream();
    test_backpressure();
    test_full_rate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fc2_bias_requant.md
# fc2_bias_requant

Downstream consumer of the fc2 bias ROM. Takes one 16-lane vector of signed 32-bit fc2 accumulator results, adds the matching packed 32-bit bias per lane, applies optional ReLU, and requantizes to signed int8 by rounding arithmetic right shift with saturation. It is a 2-stage valid/ready pipeline sitting between the fc2 MAC array and the fc3 input buffer.

## Interface
Parameters:
- NUM_NEURONS, 16, lanes per vector
- ACC_WIDTH, 32, width of each accumulator lane and each bias lane
- OUT_WIDTH, 8, width of each requantized output lane
- SHIFT, 8, requantization right-shift amount, 0..ACC_WIDTH-1
- RELU_EN, 1, 1 = clamp negatives to 0 before requantization

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- bias  input  NUM_NEURONS*ACC_WIDTH  packed biases, lane i at bits [i*ACC_WIDTH +: ACC_WIDTH]; static after reset
- in_valid  input  1  accumulator vector valid
- in_ready  output  1  block can accept a vector this cycle
- in_data  input  NUM_NEURONS*ACC_WIDTH  packed signed accumulators, same lane packing as bias
- out_valid  output  1  requantized vector valid
- out_ready  input  1  downstream accepts this cycle
- out_data  output  NUM_NEURONS*OUT_WIDTH  packed signed int8 results, lane i at [i*OUT_WIDTH +: OUT_WIDTH]
- sat_count  output  16  number of lanes saturated since reset, sticks at 16'hFFFF

## Operation
- Stage 1 (add): per lane, sum = sext33(in_data[i]) + sext33(bias[i]); clamp to signed 32-bit range [-2^31, 2^31-1]. Register s1_data and s1_valid.
- Stage 2 (requant): per lane, r = RELU_EN && s1 < 0 ? 0 : s1. If SHIFT>0, q = (sext33(r) + 2^(SHIFT-1)) >>> SHIFT (round half up, arithmetic); else q = r. Clamp q to [-128, 127]. Register out_data and out_valid.
- Saturation count: every lane clamped in stage 1 or stage 2, counted once per lane per vector even if clamped in both, increments sat_count when that stage's result is registered. Use the add of all per-vector flags (0..32); saturate at 16'hFFFF and never wrap.
- Handshake: s2_en = !out_valid || out_ready; s1_en = !s1_valid || s2_en; in_ready = s1_en (combinational, no dependence on in_valid).
- Stage 1 loads when s1_en. s1_valid <= in_valid. Stage 2 loads when s2_en. out_valid <= s1_valid.
- Data registers update only when their stage enable is high. out_data holds stable while out_valid && !out_ready.
- No state machine beyond the two valid bits. Order is preserved. Nothing is dropped or duplicated.

## Timing
- Reset (rst_n low, async): s1_valid=0, out_valid=0, out_data=0, sat_count=0, in_ready=1 as soon as reset releases.
- Latency: vector accepted at edge N appears with out_valid=1 after edge N+1. It is visible in the cycle after the second edge.
- Throughput: 1 vector/cycle while out_ready=1.
- Backpressure: with out_ready=0, at most 2 vectors are held; in_ready drops once both stages are full. in_ready rises in the same cycle out_ready rises.
- Simultaneous out handshake and in handshake on a full pipe: both stages advance; no bubble.
- Reset mid-operation: all in-flight vectors are discarded. out_valid falls asynchronously, and sat_count returns to 0.

## Test plan
- Basic: bias lane i = i*256, in_data lane i = 1000, SHIFT=8, RELU_EN=1 -> out lane i = round((1000+256i)/256); lane0=4, lane15=19; out_valid 2 cycles after accept; sat_count=0.
- Rounding/ReLU: lane sums -128, 127, 128, -1 with SHIFT=8 -> with RELU_EN=1: 0,0,1,0. With RELU_EN=0: 0 for -128 (round half up), 0, 1, 0.
- Saturation: in_data=32'h7FFFFFF0, bias=32'h00000100 on all 16 lanes -> stage-1 clamp to 2^31-1 and out lanes = 127. sat_count=16; repeat 4096 more vectors -> sat_count sticks at 16'hFFFF.
- Backpressure: stream 10 back-to-back vectors with out_ready toggling 0,0,1 repeating -> in_ready low only when both stages full; all 10 outputs in order and unchanged while stalled.
- Full-rate: in_valid=1 and out_ready=1 for 64 cycles with incrementing data -> 64 outputs on consecutive cycles, no bubbles.
- Reset mid-stream: assert rst_n=0 with 2 vectors in flight -> out_valid=0 immediately, sat_count=0. After release, the first new vector emerges with the correct result 2 cycles after accept.
